// File: rtl/sysbus_pkg.sv
// Shared Sysbus constants: tag layout, request type codes, line geometry and
// the memory responder's state encoding.
package sysbus_pkg;

    localparam int TAG_WIDTH      = 13;
    localparam int TAG_RW_BIT     = 12;
    localparam int BEATS_PER_LINE = 8;

    localparam logic       TAG_READ    = 1'b1;
    localparam logic       TAG_WRITE   = 1'b0;
    localparam logic [3:0] TYPE_MEMORY = 4'b0001;
    localparam logic [3:0] TYPE_MMIO   = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_RESP,
        ST_WDATA,
        ST_WDONE
    } resp_state_e;

    function automatic logic is_memory_type(input logic [TAG_WIDTH-1:0] tag);
        return tag[11:8] == TYPE_MEMORY;
    endfunction

endpackage

// File: rtl/resp_mem_array.sv
// Single-port 64-bit backing store; write and read both take effect on the
// clock edge, rd_dat returns the old word on a same-address write.
module resp_mem_array #(
    parameter int WORDS = 8192,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wr_dat,
    output logic [63:0]   rd_dat
);

    logic [63:0] mem_q [WORDS];
    logic [63:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_dat;
        end
        rd_dat_q <= mem_q[addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: 64-byte lines as eight 64-bit beats; first read beat
// LATENCY cycles after reqack. A read beat is held until respack; reqcyc=0 stalls writes.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 8192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqcyc,
    input  logic [63:0]          req,
    input  logic [TAG_WIDTH-1:0] reqtag,
    output logic                 reqack,
    output logic                 respcyc,
    input  logic                 respack,
    output logic [63:0]          resp,
    output logic [TAG_WIDTH-1:0] resptag
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [4:0] CNT_INIT = 5'(LATENCY - 1);

    resp_state_e          state_q, state_d;
    logic [57:0]          line_q, line_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [2:0]           beat_q, beat_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 reqack_q, reqack_d;
    logic                 respcyc_q, respcyc_d;
    logic [63:0]          resp_q, resp_d;
    logic [TAG_WIDTH-1:0] resptag_q, resptag_d;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_rdat;
    logic [2:0]    rd_beat;
    logic          unused_req_offset;

    assign unused_req_offset = ^req[5:0];

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reqcyc) begin
                    line_d  = req[63:6];
                    tag_d   = reqtag;
                    beat_d  = 3'd0;
                    cnt_d   = CNT_INIT;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (tag_q[TAG_RW_BIT] == TAG_READ) begin
                    // LATENCY=1 skips WAIT so the first beat still lands one cycle after reqack.
                    if (cnt_q == 5'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q - 5'd1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: begin
                if (respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WDATA: begin
                if (reqcyc) begin
                    mem_we = is_memory_type(tag_q) && !reset;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = ST_WDONE;
                    end
                end
            end
            ST_WDONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reads run one word ahead of the beat shown next cycle, so mem_rdat
        // already holds the following beat whenever respack advances the index.
        rd_beat = (state_d == ST_RESP) ? beat_d + 3'd1 : 3'd0;
        if (state_q == ST_WDATA) begin
            mem_addr = AW'({line_q, beat_q});
        end else begin
            mem_addr = AW'({line_d, rd_beat});
        end

        reqack_d  = (state_d == ST_ACK) || (state_d == ST_WDONE);
        respcyc_d = (state_d == ST_RESP);
        resptag_d = respcyc_d ? tag_d : '0;
        resp_d    = '0;
        if (state_d == ST_RESP) begin
            if (state_q != ST_RESP || respack) begin
                resp_d = is_memory_type(tag_q) ? mem_rdat : 64'd0;
            end else begin
                resp_d = resp_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    resp_mem_array #(
        .WORDS (MEM_WORDS)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_we),
        .addr   (mem_addr),
        .wr_dat (req),
        .rd_dat (mem_rdat)
    );

    assign reqack  = reqack_q;
    assign respcyc = respcyc_q;
    assign resp    = resp_q;
    assign resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: read beats are predicted from a
// word-level memory model when each request is issued and compared as accepted.
module tb_sysbus_mem_responder;

    localparam int LAT   = 4;
    localparam int WORDS = 8192;

    typedef struct packed {
        logic [63:0] data;
        logic [12:0] tag;
    } sb_item_t;

    logic        clk;
    logic        reset;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic        respack;
    logic [63:0] resp;
    logic [12:0] resptag;

    int          n_checks;
    int          n_errors;
    sb_item_t    sb_q[$];
    logic [63:0] model_mem [WORDS];

    sysbus_mem_responder #(
        .LATENCY   (LAT),
        .MEM_WORDS (WORDS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqcyc  (reqcyc),
        .req     (req),
        .reqtag  (reqtag),
        .reqack  (reqack),
        .respcyc (respcyc),
        .respack (respack),
        .resp    (resp),
        .resptag (resptag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic int widx(input logic [63:0] addr, input int beat);
        logic [63:0] w;
        w = ((addr >> 6) * 64'd8 + 64'(beat)) % 64'(WORDS);
        return int'(w);
    endfunction

    function automatic logic tag_is_mem(input logic [12:0] tag);
        return tag[11:8] == 4'b0001;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a read and runs the beat handshake; stall_beat/stall_n hold respack
    // low on one beat, abort_after asserts reset once that many beats are taken.
    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                           input int stall_beat, input int stall_n, input int abort_after,
                           output int first_k, output int last_k, output int beat_cycles);
        int beat_idx;
        int stall_left;
        int n_ack;
        sb_item_t e;
        beat_idx    = 0;
        stall_left  = stall_n;
        n_ack       = 0;
        first_k     = -1;
        last_k      = -1;
        beat_cycles = 0;
        for (int b = 0; b < 8; b++) begin
            e.data = tag_is_mem(tag) ? model_mem[widx(addr, b)] : 64'd0;
            e.tag  = tag;
            sb_q.push_back(e);
        end
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        step();
        reqcyc = 1'b0;
        req    = '0;
        chk("rd_reqack", {63'd0, reqack}, 64'd1);
        for (int k = 1; k <= 100 && beat_idx < 8; k++) begin
            if (reqack) n_ack++;
            if (abort_after >= 0 && beat_idx == abort_after) begin
                reset   = 1'b1;
                respack = 1'b0;
                step();
                chk("abort_respcyc", {63'd0, respcyc}, 64'd0);
                chk("abort_resp", resp, 64'd0);
                reset = 1'b0;
                sb_q.delete();
                return;
            end
            if (respcyc) begin
                beat_cycles++;
                if (first_k < 0) first_k = k;
                if (sb_q.size() == 0) begin
                    chk("rd_extra_beat", {63'd0, respcyc}, 64'd0);
                    respack = 1'b1;
                end else if (beat_idx == stall_beat && stall_left > 0) begin
                    respack = 1'b0;
                    stall_left--;
                    chk("rd_hold", resp, sb_q[0].data);
                end else begin
                    respack = 1'b1;
                    e = sb_q.pop_front();
                    chk("rd_data", resp, e.data);
                    chk("rd_tag", {51'd0, resptag}, {51'd0, e.tag});
                    beat_idx++;
                    last_k = k;
                end
            end else begin
                respack = 1'b0;
            end
            step();
        end
        respack = 1'b0;
        chk("rd_beats_done", 64'(beat_idx), 64'd8);
        chk("rd_tail_respcyc", {63'd0, respcyc}, 64'd0);
        chk("rd_reqack_count", 64'(n_ack), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] base, input int bubble_after, output int ack_k);
        int  b;
        int  k;
        logic bubbled;
        b       = 0;
        bubbled = 1'b0;
        ack_k   = -1;
        reqcyc  = 1'b1;
        req     = addr;
        reqtag  = tag;
        step();
        reqcyc = 1'b0;
        chk("wr_reqack", {63'd0, reqack}, 64'd1);
        step();
        k = 2;
        while (k <= 60 && ack_k < 0) begin
            if (reqack) begin
                ack_k = k;
            end else if (b < 8) begin
                if (bubble_after >= 0 && b == bubble_after + 1 && !bubbled) begin
                    reqcyc  = 1'b0;
                    bubbled = 1'b1;
                end else begin
                    reqcyc = 1'b1;
                    req    = base + 64'(b);
                    if (tag_is_mem(tag)) model_mem[widx(addr, b)] = base + 64'(b);
                    b++;
                end
            end else begin
                reqcyc = 1'b0;
            end
            if (ack_k < 0) begin
                step();
                k++;
            end
        end
        reqcyc = 1'b0;
        req    = '0;
        step();
        chk("wr_ack_single", {63'd0, reqack}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int fk, lk, bc, ak;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = 64'd0;
        reset   = 1'b1;
        reqcyc  = 1'b1;
        req     = 64'h1000;
        reqtag  = 13'h1201;
        respack = 1'b0;

        // Reset held with a pending request: outputs must stay quiet.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_reqack", {63'd0, reqack}, 64'd0);
        end
        chk("rst_respcyc", {63'd0, respcyc}, 64'd0);
        chk("rst_resp", resp, 64'd0);
        chk("rst_resptag", {51'd0, resptag}, 64'd0);
        reset = 1'b0;

        // The held request is taken on the first edge out of reset (MMIO read).
        do_read(64'h1000, 13'h1201, -1, 0, -1, fk, lk, bc);
        chk("mmio_first_lat", 64'(fk), 64'(LAT + 1));

        do_write(64'h1000, 13'h0102, 64'h1000, -1, ak);
        chk("wr_ack_lat", 64'(ak), 64'd10);

        do_read(64'h1000, 13'h1100, -1, 0, -1, fk, lk, bc);
        chk("rd_first_lat", 64'(fk), 64'(LAT + 1));
        chk("rd_last_lat", 64'(lk), 64'(LAT + 8));
        chk("rd_beat_cycles", 64'(bc), 64'd8);

        do_read(64'h1000, 13'h1105, 2, 3, -1, fk, lk, bc);
        chk("bp_beat_cycles", 64'(bc), 64'd11);
        chk("bp_last_lat", 64'(lk), 64'(LAT + 11));

        do_write(64'h2000, 13'h0107, 64'hA0, 3, ak);
        chk("wr_bubble_ack_lat", 64'(ak), 64'd11);

        do_write(64'h2000, 13'h0208, 64'hDEAD_0000, -1, ak);
        chk("mmio_wr_ack_lat", 64'(ak), 64'd10);

        do_read(64'h2000, 13'h1109, -1, 0, -1, fk, lk, bc);
        chk("wb_last_lat", 64'(lk), 64'(LAT + 8));

        do_write(64'h0, 13'h010A, 64'h5550, -1, ak);
        do_read(64'h20000, 13'h110B, -1, 0, -1, fk, lk, bc);
        chk("wrap_beat_cycles", 64'(bc), 64'd8);

        do_read(64'h1000, 13'h120C, -1, 0, -1, fk, lk, bc);

        do_read(64'h2000, 13'h110D, -1, 0, 4, fk, lk, bc);
        do_read(64'h1000, 13'h110E, -1, 0, -1, fk, lk, bc);
        chk("post_abort_first_lat", 64'(fk), 64'(LAT + 1));
        chk("post_abort_last_lat", 64'(lk), 64'(LAT + 8));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
